// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit XNOR pattern generator and its receive-side checker.
// Taps 7 and 3, left shift, feedback into bit 0.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 3;
  localparam logic [LFSR_W-1:0] LOCKUP = 8'hFF;

  typedef enum logic {HUNT, LOCKED} state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ~(x[TAP_HI] ^ x[TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  count <= '0;
    else if (clr)                count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the XNOR pattern generator: hunts for lock on the
// incoming stream, then free-runs a prediction and flags/counts mismatches.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              clear,
  output logic              locked,
  output logic              error,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  word_count
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] prev_q, prev_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        miss_q, miss_d;
  logic              seeded_q, seeded_d;
  logic              error_d, sticky_d;
  logic              err_inc, word_inc;
  logic [3:0]        match_inc, miss_inc;

  assign match_inc = match_q + 4'd1;
  assign miss_inc  = miss_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      prev_q     <= '0;
      exp_q      <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      seeded_q   <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      seeded_q   <= seeded_d;
      locked     <= (state_d == LOCKED);
      error      <= error_d;
      err_sticky <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    seeded_d = seeded_q;
    error_d  = 1'b0;
    sticky_d = err_sticky;
    err_inc  = 1'b0;
    word_inc = 1'b0;

    if (enable) begin
      unique case (state_q)
        HUNT: begin
          prev_d   = data_in;
          seeded_d = 1'b1;
          if (seeded_q) begin
            // LOCKUP maps onto itself, so it would otherwise look like a valid transition
            if (data_in == lfsr_next(prev_q) && data_in != LOCKUP) begin
              match_d = match_inc;
              if (match_inc == LOCK_N) begin
                state_d = LOCKED;
                exp_d   = lfsr_next(data_in);
                miss_d  = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
        LOCKED: begin
          word_inc = 1'b1;
          exp_d    = lfsr_next(exp_q);
          if (data_in != exp_q) begin
            error_d  = 1'b1;
            sticky_d = 1'b1;
            err_inc  = 1'b1;
            miss_d   = miss_inc;
            if (miss_inc == LOSS_N) begin
              // The failing word seeds the next hunt so re-lock needs no extra sample
              state_d  = HUNT;
              match_d  = '0;
              prev_d   = data_in;
              seeded_d = 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear) sticky_d = 1'b0;
  end

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (clear),
    .count (err_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (word_inc),
    .clr   (clear),
    .count (word_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker; narrow counters so saturation is reachable quickly.
module tb_lfsr_checker;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, enable, clear;
  logic [7:0]    data_in;
  logic          locked, error, err_sticky;
  logic [CW-1:0] err_count, word_count;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .clear      (clear),
    .locked     (locked),
    .error      (error),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .word_count (word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic cyc(input logic en, input logic [7:0] d, input logic clr = 1'b0);
    enable  = en;
    data_in = d;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0; enable = 1'b0; clear = 1'b0; data_in = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic lock_up;
    cyc(1, 8'h00); cyc(1, 8'h01); cyc(1, 8'h03); cyc(1, 8'h07); cyc(1, 8'h0F);
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[3])};
  endfunction

  initial begin
    logic [7:0] seq [5];
    logic [7:0] e;
    seq = '{8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0};

    reset = 1'b0; enable = 1'b0; clear = 1'b0; data_in = 8'h00;
    @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);
    reset = 1'b1;

    // clean generator stream
    cyc(1, 8'h00); cyc(1, 8'h01); cyc(1, 8'h03); cyc(1, 8'h07);
    chk("prelock", locked, 0);
    cyc(1, 8'h0F);
    chk("lock", locked, 1);
    chk("lock_words", word_count, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i]);
      chk("clean_error", error, 0);
    end
    chk("clean_words", word_count, 5);
    chk("clean_errs", err_count, 0);

    // single injected error, prediction free-runs
    do_reset; lock_up;
    cyc(1, 8'h1E);
    cyc(1, 8'h3D);
    chk("inj_error", error, 1);
    chk("inj_sticky", err_sticky, 1);
    chk("inj_errs", err_count, 1);
    cyc(1, 8'h78);
    chk("inj_next_error", error, 0);
    chk("inj_hold_lock", locked, 1);
    chk("inj_words", word_count, 3);
    cyc(1, 8'hF0);

    // clear on a good word, then three corrupt words drop lock
    cyc(1, 8'hE0, 1'b1);
    chk("clr_errs", err_count, 0);
    chk("clr_words", word_count, 0);
    chk("clr_sticky", err_sticky, 0);
    cyc(1, 8'hAA); cyc(1, 8'h55);
    chk("miss2_locked", locked, 1);
    cyc(1, 8'hAA);
    chk("loss_locked", locked, 0);
    chk("loss_errs", err_count, 3);
    chk("loss_words", word_count, 3);
    cyc(1, 8'h55); cyc(1, 8'hAB); cyc(1, 8'h57);
    chk("relock_pending", locked, 0);
    cyc(1, 8'hAF);
    chk("relock", locked, 1);
    cyc(1, 8'h5F);
    chk("relock_error", error, 0);
    chk("relock_words", word_count, 4);
    chk("relock_sticky", err_sticky, 1);

    // clear coincident with a mismatch (expected BE)
    cyc(1, 8'h00, 1'b1);
    chk("clrerr_pulse", error, 1);
    chk("clrerr_errs", err_count, 0);
    chk("clrerr_sticky", err_sticky, 0);
    chk("clrerr_words", word_count, 0);
    cyc(1, 8'h00);
    chk("second_err_errs", err_count, 1);

    // asynchronous reset mid-lock, away from any clock edge
    #2 reset = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_error", error, 0);
    chk("async_sticky", err_sticky, 0);
    chk("async_errs", err_count, 0);
    chk("async_words", word_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1, 8'h1E); cyc(1, 8'h3C); cyc(1, 8'h78); cyc(1, 8'hF0);
    chk("fresh_seed_pending", locked, 0);
    cyc(1, 8'hE0);
    chk("fresh_seed_lock", locked, 1);

    // lockup word never locks
    do_reset;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 8'hFF);
      chk("ff_locked", locked, 0);
    end
    chk("ff_errs", err_count, 0);

    // enable toggling; idle data must be ignored
    do_reset;
    cyc(1, 8'h00); cyc(0, 8'h55);
    cyc(1, 8'h01); cyc(0, 8'h55);
    cyc(1, 8'h03); cyc(0, 8'h55);
    cyc(1, 8'h07); cyc(0, 8'h55);
    chk("en_prelock", locked, 0);
    cyc(1, 8'h0F); cyc(0, 8'h55);
    chk("en_lock", locked, 1);
    chk("en_lock_words", word_count, 0);
    cyc(1, 8'h1E); cyc(0, 8'hAA);
    chk("en_words1", word_count, 1);
    cyc(1, 8'h33);
    chk("en_error", error, 1);
    cyc(0, 8'h3C);
    chk("en_idle_error", error, 0);
    chk("en_idle_errs", err_count, 1);
    chk("en_idle_words", word_count, 2);
    chk("en_idle_locked", locked, 1);

    // saturation: alternate bad/good so lock is held
    do_reset; lock_up;
    e = 8'h1E;
    for (int i = 0; i < 40; i++) begin
      cyc(1, (i % 2 == 0) ? (e ^ 8'h01) : e);
      e = nxt(e);
    end
    chk("sat_errs", err_count, 15);
    chk("sat_words", word_count, 15);
    chk("sat_locked", locked, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
